// File: rtl/adc_sd_responder_pkg.sv
// adc_sd_responder_pkg: shared frame geometry defaults and FSM encodings.
package adc_sd_responder_pkg;
  localparam int DEF_SAMPLE_WIDTH = 12;
  localparam int DEF_LEAD_ZEROS = 4;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/adc_sd_responder_if.sv
// adc_sd_responder_if: sample handshake plus the three-wire serial ADC bus.
interface adc_sd_responder_if #(
  parameter int SAMPLE_WIDTH = 12
);
  logic [SAMPLE_WIDTH-1:0] sample_data;
  logic sample_valid;
  logic sample_ready;
  logic adc_clk;
  logic adc_cs;
  logic adc_sd;
  modport master (
    output sample_data, sample_valid, adc_clk, adc_cs,
    input  sample_ready, adc_sd
  );
  modport slave (
    input  sample_data, sample_valid, adc_clk, adc_cs,
    output sample_ready, adc_sd
  );
endinterface

// File: rtl/adc_sd_responder_sync_edge.sv
// adc_sd_responder_sync_edge: N-stage synchroniser with level, rise and fall pulses.
module adc_sd_responder_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  assign level = sync[STAGES-1];
  assign rise = ~prev & level;
  assign fall = prev & ~level;
endmodule

// File: rtl/adc_sd_responder.sv
// adc_sd_responder: emulates a 12-bit serial ADC slave, shifting buffered samples out on adc_sd.
module adc_sd_responder
  import adc_sd_responder_pkg::*;
#(
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int LEAD_ZEROS   = DEF_LEAD_ZEROS,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic resetn,
  adc_sd_responder_if.slave bus,
  output logic busy,
  output logic frame_done,
  output logic underrun
);
  localparam int FRAME = LEAD_ZEROS + SAMPLE_WIDTH;
  localparam int IDX_W = $clog2(FRAME + 1);
  state_t state;
  logic [SAMPLE_WIDTH-1:0] hold;
  logic [FRAME-1:0] shreg;
  logic [IDX_W-1:0] bit_idx;
  logic fresh, accept, load;
  logic cs_level, cs_rise, cs_fall, sclk_level, sclk_rise, sclk_fall;
  logic unused_sync;
  adc_sd_responder_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .resetn(resetn), .d(bus.adc_cs),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );
  adc_sd_responder_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .resetn(resetn), .d(bus.adc_clk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );
  assign unused_sync = &{1'b0, cs_level, sclk_level, sclk_rise};
  assign bus.sample_ready = ~fresh;
  assign accept = bus.sample_valid & ~fresh;
  assign load = (state == IDLE) & cs_fall;
  // Shift register moves left; the bit behind the MSB is what the next falling edge presents.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      hold <= '0;
      shreg <= '0;
      bit_idx <= '0;
      fresh <= 1'b0;
      bus.adc_sd <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun <= 1'b0;
      fresh <= accept | (fresh & ~load);
      if (accept) hold <= bus.sample_data;
      case (state)
        IDLE: if (load) begin
          state <= SHIFT;
          busy <= 1'b1;
          shreg <= {{LEAD_ZEROS{1'b0}}, hold};
          bit_idx <= '0;
          bus.adc_sd <= 1'b0;
          underrun <= ~fresh;
        end
        SHIFT: if (cs_rise) begin
          state <= IDLE;
          busy <= 1'b0;
          bus.adc_sd <= 1'b0;
        end else if (sclk_fall) begin
          bit_idx <= bit_idx + 1'b1;
          shreg <= shreg << 1;
          bus.adc_sd <= (bit_idx == IDX_W'(FRAME - 1)) ? 1'b0 : shreg[FRAME-2];
          if (bit_idx == IDX_W'(FRAME - 1)) begin
            state <= DONE;
            busy <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        DONE: if (cs_rise) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_adc_sd_responder.sv
// tb_adc_sd_responder: drives an SPI-style ADC master against a queue-based sample model.
module tb_adc_sd_responder;
  localparam int SW = 12;
  localparam int LZ = 4;
  localparam int SS = 2;
  localparam int FRAME = LZ + SW;
  localparam int HALF = 8;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy, frame_done, underrun;
  int n_checks = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  int ur_cnt = 0;
  logic [SW-1:0] q[$];
  logic [SW-1:0] last_val;
  adc_sd_responder_if #(.SAMPLE_WIDTH(SW)) bus();
  adc_sd_responder #(.SAMPLE_WIDTH(SW), .LEAD_ZEROS(LZ), .SYNC_STAGES(SS)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (underrun) ur_cnt++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic [SW-1:0] v);
    int n = 0;
    @(negedge clk);
    bus.sample_data = v;
    bus.sample_valid = 1'b1;
    while (!bus.sample_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!bus.sample_ready) begin
      n_fail++;
      $display("FAIL push_timeout sample_ready=%b required 1", bus.sample_ready);
    end else q.push_back(v);
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask
  task automatic model_start(output logic [SW-1:0] v, output logic ur);
    ur = (q.size() == 0);
    v = ur ? last_val : q.pop_front();
    last_val = v;
  endtask
  task automatic drive_frame(input int nfalls, output logic [FRAME-1:0] bits, output logic extra);
    bits = '0;
    extra = 1'b0;
    @(negedge clk);
    bus.adc_cs = 1'b0;
    wait_neg(HALF);
    for (int k = 0; k < nfalls; k++) begin
      if (k < FRAME) bits[FRAME-1-k] = bus.adc_sd;
      else extra |= bus.adc_sd;
      bus.adc_clk = 1'b0;
      wait_neg(HALF);
      bus.adc_clk = 1'b1;
      wait_neg(HALF);
    end
    if (nfalls >= FRAME) extra |= bus.adc_sd;
  endtask
  task automatic end_frame();
    bus.adc_cs = 1'b1;
    wait_neg(HALF);
  endtask
  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.adc_sd !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs sd=%b busy=%b fd=%b ur=%b required all 0", bus.adc_sd, busy, frame_done, underrun);
    end
    n_checks++;
    if (bus.sample_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got %b required 1", bus.sample_ready);
    end
    wait_neg(3);
    resetn = 1'b1;
    wait_neg(4);
  endtask
  task automatic test_basic();
    logic [FRAME-1:0] bits;
    logic extra, eur;
    logic [SW-1:0] ev;
    int fd0, ur0;
    push(12'hA5C);
    fd0 = fd_cnt;
    ur0 = ur_cnt;
    model_start(ev, eur);
    drive_frame(FRAME, bits, extra);
    end_frame();
    n_checks++;
    if (bits !== 16'h0A5C) begin
      n_fail++;
      $display("FAIL basic_bits got %h required 0a5c", bits);
    end
    n_checks++;
    if (fd_cnt - fd0 !== 1 || ur_cnt - ur0 !== 0) begin
      n_fail++;
      $display("FAIL basic_pulses frame_done=%0d underrun=%0d required 1 and 0", fd_cnt - fd0, ur_cnt - ur0);
    end
    n_checks++;
    if (bus.sample_ready !== 1'b1 || extra !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ready ready=%b tail_sd=%b required 1 and 0", bus.sample_ready, extra);
    end
  endtask
  task automatic test_underrun();
    logic [FRAME-1:0] bits;
    logic extra, eur;
    logic [SW-1:0] ev;
    int ur0;
    push(SW'($urandom_range(0, 4095)));
    for (int f = 0; f < 2; f++) begin
      ur0 = ur_cnt;
      model_start(ev, eur);
      drive_frame(FRAME, bits, extra);
      end_frame();
      n_checks++;
      if (bits !== {{LZ{1'b0}}, ev}) begin
        n_fail++;
        $display("FAIL underrun_bits frame %0d got %h required %h", f, bits, {{LZ{1'b0}}, ev});
      end
      n_checks++;
      if (ur_cnt - ur0 !== int'(eur)) begin
        n_fail++;
        $display("FAIL underrun_pulse frame %0d got %0d required %0d", f, ur_cnt - ur0, eur);
      end
    end
  endtask
  task automatic test_accept_on_load();
    logic [FRAME-1:0] b1, b2;
    logic x1, x2, eur;
    logic [SW-1:0] ev;
    int ur0;
    push(12'h123);
    ur0 = ur_cnt;
    model_start(ev, eur);
    fork
      drive_frame(FRAME, b1, x1);
      begin
        repeat (2) @(negedge clk);
        push(12'h456);
      end
    join
    end_frame();
    model_start(ev, eur);
    drive_frame(FRAME, b2, x2);
    end_frame();
    n_checks++;
    if (b1 !== 16'h0123 || b2 !== 16'h0456) begin
      n_fail++;
      $display("FAIL accept_on_load frames got %h %h required 0123 0456", b1, b2);
    end
    n_checks++;
    if (ur_cnt - ur0 !== 0) begin
      n_fail++;
      $display("FAIL accept_on_load_underrun got %0d required 0", ur_cnt - ur0);
    end
  endtask
  task automatic test_abort();
    logic [FRAME-1:0] bits, exp;
    logic extra, eur;
    logic [SW-1:0] ev;
    int fd0, ur0, n;
    push(SW'($urandom_range(0, 4095)));
    fd0 = fd_cnt;
    model_start(ev, eur);
    exp = {{LZ{1'b0}}, ev};
    drive_frame(7, bits, extra);
    bus.adc_cs = 1'b1;
    n = 0;
    while ((bus.adc_sd !== 1'b0 || busy !== 1'b0) && n < SS + 2) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (bus.adc_sd !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle sd=%b busy=%b required 0 0", bus.adc_sd, busy);
    end
    n_checks++;
    if (bits[FRAME-1:FRAME-7] !== exp[FRAME-1:FRAME-7]) begin
      n_fail++;
      $display("FAIL abort_prefix got %b required %b", bits[FRAME-1:FRAME-7], exp[FRAME-1:FRAME-7]);
    end
    wait_neg(HALF);
    n_checks++;
    if (fd_cnt - fd0 !== 0) begin
      n_fail++;
      $display("FAIL abort_frame_done got %0d required 0", fd_cnt - fd0);
    end
    ur0 = ur_cnt;
    model_start(ev, eur);
    drive_frame(FRAME, bits, extra);
    end_frame();
    n_checks++;
    if (bits !== {{LZ{1'b0}}, ev} || ur_cnt - ur0 !== int'(eur)) begin
      n_fail++;
      $display("FAIL abort_next got %h ur=%0d required %h ur=%0d", bits, ur_cnt - ur0, {{LZ{1'b0}}, ev}, eur);
    end
  endtask
  task automatic test_reset_mid_frame();
    logic [FRAME-1:0] bits;
    logic extra, eur;
    logic [SW-1:0] ev;
    int ur0;
    push(SW'($urandom_range(0, 4095)) | 12'h020);
    model_start(ev, eur);
    drive_frame(10, bits, extra);
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (bus.adc_sd !== 1'b0 || busy !== 1'b0 || bus.sample_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset sd=%b busy=%b ready=%b required 0 0 1", bus.adc_sd, busy, bus.sample_ready);
    end
    q.delete();
    last_val = '0;
    bus.adc_cs = 1'b1;
    bus.adc_clk = 1'b1;
    wait_neg(3);
    resetn = 1'b1;
    wait_neg(4);
    push(12'hFFF);
    ur0 = ur_cnt;
    model_start(ev, eur);
    drive_frame(FRAME, bits, extra);
    end_frame();
    n_checks++;
    if (bits !== 16'h0FFF || ur_cnt - ur0 !== 0) begin
      n_fail++;
      $display("FAIL reset_recover got %h ur=%0d required 0fff ur=0", bits, ur_cnt - ur0);
    end
  endtask
  task automatic test_extra_falls();
    logic [FRAME-1:0] bits;
    logic extra, eur;
    logic [SW-1:0] ev;
    int fd0;
    push(SW'($urandom_range(0, 4095)));
    fd0 = fd_cnt;
    model_start(ev, eur);
    drive_frame(FRAME + 3, bits, extra);
    n_checks++;
    if (bits !== {{LZ{1'b0}}, ev} || extra !== 1'b0) begin
      n_fail++;
      $display("FAIL extra_falls_data got %h tail=%b required %h tail=0", bits, extra, {{LZ{1'b0}}, ev});
    end
    n_checks++;
    if (fd_cnt - fd0 !== 1) begin
      n_fail++;
      $display("FAIL extra_falls_done got %0d required 1", fd_cnt - fd0);
    end
    n_checks++;
    if (dut.state !== 2'd2) begin
      n_fail++;
      $display("FAIL extra_falls_state_cs_low got %0d required 2", dut.state);
    end
    end_frame();
    n_checks++;
    if (dut.state !== 2'd0) begin
      n_fail++;
      $display("FAIL extra_falls_state_cs_high got %0d required 0", dut.state);
    end
  endtask
  task automatic test_random();
    logic [FRAME-1:0] bits;
    logic extra, eur;
    logic [SW-1:0] ev;
    int ur0, fd0;
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 2) != 0) push(SW'($urandom_range(0, 4095)));
      ur0 = ur_cnt;
      fd0 = fd_cnt;
      model_start(ev, eur);
      drive_frame(FRAME, bits, extra);
      end_frame();
      n_checks++;
      if (bits !== {{LZ{1'b0}}, ev} || ur_cnt - ur0 !== int'(eur) || fd_cnt - fd0 !== 1) begin
        n_fail++;
        $display("FAIL random_frame %0d got %h ur=%0d fd=%0d required %h ur=%0d fd=1", i, bits, ur_cnt - ur0, fd_cnt - fd0, {{LZ{1'b0}}, ev}, eur);
      end
    end
  endtask
  initial begin
    bus.sample_data = '0;
    bus.sample_valid = 1'b0;
    bus.adc_clk = 1'b1;
    bus.adc_cs = 1'b1;
    last_val = '0;
    test_reset();
    test_basic();
    test_underrun();
    test_accept_on_load();
    test_abort();
    test_reset_mid_frame();
    test_extra_falls();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_sd_responder.md
Name: adc_sd_responder

Overview:
Slave-side emulator of the 12-bit serial ADC interface (CS/SCLK/SDATA, 16-clock frame: 4 leading zeros, then 12 data bits MSB first).
Runs on the pixel clock. It oversamples the master's adc_clk/adc_cs and shifts a buffered sample out on adc_sd.
Used for loopback self-test of the waterfall chain: a tone/pattern generator feeds samples in, and the existing ADC reader consumes them, so no external ADC is needed.

Parameters:
SAMPLE_WIDTH, 12, data bits per frame.
LEAD_ZEROS, 4, zero bits before the MSB; frame length = LEAD_ZEROS + SAMPLE_WIDTH.
SYNC_STAGES, 2, synchroniser depth on adc_clk and adc_cs (minimum 2).

Ports:
clk  in  1  system clock (pixel clock); all logic on posedge.
resetn  in  1  asynchronous active-low reset.
sample_data  in  SAMPLE_WIDTH  next sample to transmit.
sample_valid  in  1  sample_data valid; accepted when sample_valid && sample_ready.
sample_ready  out  1  holding register empty.
adc_clk  in  1  SCLK from the master (asynchronous to clk).
adc_cs  in  1  active-low chip select from the master (asynchronous).
adc_sd  out  1  serial data to the master.
busy  out  1  frame in progress (state SHIFT).
frame_done  out  1  one-cycle pulse when the last bit's falling edge is consumed.
underrun  out  1  one-cycle pulse when a frame starts with no fresh sample.

Behaviour:
- Reset values:
  - adc_sd=0, busy=0, frame_done=0, underrun=0, sample_ready=1.
  - hold/shift registers=0, bit index=0, state=IDLE.
  - synchronisers preset to idle level: cs=1, sclk=1.
- Input synchronisation:
  - adc_clk and adc_cs each pass through SYNC_STAGES flops, plus one delayed copy for edge detection.
  - cs_fall = prev 1 / now 0; cs_rise = prev 0 / now 1; sclk_fall = prev 1 / now 0.
- Holding register:
  - On accept, store sample_data, set a fresh flag, and drop sample_ready.
  - The fresh flag clears and sample_ready rises on the cycle the hold value is loaded into the shift register.
  - Accept and load in the same cycle: the load takes the old hold value, and the newly accepted sample becomes fresh.
- FSM IDLE -> SHIFT:
  - Trigger: cs_fall.
  - Shift register <= {LEAD_ZEROS zeros, hold}. Bit index <= 0. adc_sd <= first bit (0).
  - If the fresh flag is clear, reuse the last hold value and pulse underrun.
- In SHIFT:
  - Each sclk_fall increments the bit index and drives the next bit on adc_sd: bit index i maps to frame bit i, MSB-side first.
  - The sample MSB appears after the LEAD_ZEROS-th falling edge.
  - After the (LEAD_ZEROS+SAMPLE_WIDTH)-th sclk_fall: go to DONE, pulse frame_done, adc_sd <= 0.
- DONE:
  - adc_sd is held 0 and further sclk_fall edges are ignored.
  - cs_rise -> IDLE.
- Abort rules:
  - cs_rise in SHIFT -> IDLE immediately, adc_sd <= 0, no frame_done. The sample counts as consumed.
  - cs_fall while in DONE or SHIFT is impossible (cs must rise first) and is ignored.
- Simultaneous cs_fall and sclk_fall in IDLE: only the cs_fall is acted on; that sclk edge does not advance the index.
- Latency: adc_sd updates SYNC_STAGES+1 clk cycles after the physical edge. The master's SCLK low and high phases must each be ≥ SYNC_STAGES+2 clk cycles; this is a documented constraint, not checked.
- adc_sd is registered and glitch-free; it is never tristated and reads 0 whenever CS is high.
- Asynchronous reset mid-frame returns everything to reset values. The master then sees a 0 stream.

Decomposition:
- Shared package: constants only — LEAD_ZEROS and SAMPLE_WIDTH defaults, plus FSM state encodings (IDLE=0, SHIFT=1, DONE=2).
- One natural sub-module, sync_edge: an N-stage synchroniser that outputs the level plus rise and fall pulses.
  - Instantiated twice, for adc_cs and adc_clk.
  - Its flop reset level is a parameter.

Test Plan:
1. Load 0xA5C, then drive a master frame (CS low, 16 SCLK cycles, 8 clk per half-period). Required: sampled bits 0000_1010_0101_1100, one frame_done, no underrun, sample_ready back to 1.
2. Run two frames back-to-back with only 0x123 loaded. Required: frame 1 returns 0x123; frame 2 returns 0x123 again with an underrun pulse at its cs_fall.
3. Assert sample_valid with 0x456 on the exact cycle frame 1 loads 0x123. Required: frame 1 = 0x123, frame 2 = 0x456, no underrun.
4. Raise CS after 7 SCLK falls. Required: adc_sd=0 within SYNC_STAGES+2 cycles, busy=0, no frame_done; the next frame shows underrun if nothing new was loaded.
5. Deassert resetn mid-frame (after 10 bits). Required: adc_sd=0, busy=0, and sample_ready=1 asynchronously; after release, a full new frame of 0xFFF reads back 0000_1111_1111_1111.
6. Give 3 extra SCLK falls after bit 16 with CS still low. Required: adc_sd stays 0, frame_done pulses exactly once, and the state leaves DONE only on cs_rise.
